// File: rtl/sprite_capture_writer_if.sv
// Pixel-stream, capture-control and RAM write-port signals of the sprite capture writer.
interface sprite_capture_writer_if #(
    parameter int ADDR_W = 15
);
    logic              capture_req_in;
    logic [10:0]       x_in;
    logic [9:0]        y_in;
    logic              pixel_valid_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic [11:0]       pixel_in;
    logic              we_out;
    logic [ADDR_W-1:0] addr_out;
    logic [7:0]        data_out;
    logic              busy_out;
    logic              done_out;
    logic              incomplete_out;

    modport master (
        output capture_req_in, x_in, y_in, pixel_valid_in, hcount_in, vcount_in, pixel_in,
        input  we_out, addr_out, data_out, busy_out, done_out, incomplete_out
    );

    modport slave (
        input  capture_req_in, x_in, y_in, pixel_valid_in, hcount_in, vcount_in, pixel_in,
        output we_out, addr_out, data_out, busy_out, done_out, incomplete_out
    );
endinterface

// File: rtl/sprite_capture_writer.sv
// Sprite capture writer: grabs a WIDTH x HEIGHT window of the live RGB444 pixel stream at a
// requested (x,y) and writes it row-major as RGB332 words into a sprite RAM write port.
module sprite_capture_writer #(
    parameter int WIDTH  = 900,
    parameter int HEIGHT = 24,
    parameter int ADDR_W = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input logic                    pixel_clk_in,
    input logic                    rst_in,
    sprite_capture_writer_if.slave bus
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [11:0] WIN_W = 12'(WIDTH);
    localparam logic [10:0] WIN_H = 11'(HEIGHT);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [10:0]       xr;
    logic [9:0]        yr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_cnt;
    logic              incomplete;
    logic              incomplete_next;
    logic              latch_req;
    logic              take;
    logic              frame_start;
    logic              in_win;
    logic              last_pixel;
    logic [11:0]       h_ext;
    logic [11:0]       x_hi;
    logic [10:0]       v_ext;
    logic [10:0]       y_hi;

    // RGB444 -> RGB332 by dropping low bits of each channel (no rounding).
    function automatic logic [7:0] to_rgb332(input logic [11:0] rgb444);
        return {rgb444[11:9], rgb444[7:5], rgb444[3:2]};
    endfunction

    // Window bounds are compared one bit wider than the coordinates so xr+WIDTH cannot wrap.
    assign h_ext       = {1'b0, bus.hcount_in};
    assign v_ext       = {1'b0, bus.vcount_in};
    assign x_hi        = {1'b0, xr} + WIN_W;
    assign y_hi        = {1'b0, yr} + WIN_H;
    assign frame_start = bus.pixel_valid_in && (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
    assign in_win      = bus.pixel_valid_in
                         && (h_ext >= {1'b0, xr}) && (h_ext < x_hi)
                         && (v_ext >= {1'b0, yr}) && (v_ext < y_hi);
    assign last_pixel  = (col == COL_LAST) && (row == ROW_LAST);
    assign bus.incomplete_out = incomplete;

    // State register; the incomplete flag is only ever set for the single DONE cycle.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            incomplete <= 1'b0;
        end else begin
            state      <= state_next;
            incomplete <= incomplete_next;
        end
    end

    // Next-state, capture decisions and status outputs.
    always_comb begin
        state_next      = state;
        incomplete_next = 1'b0;
        latch_req       = 1'b0;
        take            = 1'b0;
        bus.busy_out    = 1'b0;
        bus.done_out    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.capture_req_in) begin
                    latch_req  = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                bus.busy_out = 1'b1;
                // The frame-start pixel itself already belongs to the capture.
                if (frame_start) begin
                    state_next = CAPTURE;
                    if (in_win) begin
                        take = 1'b1;
                        if (last_pixel) state_next = DONE;
                    end
                end
            end
            CAPTURE: begin
                bus.busy_out = 1'b1;
                // A second frame start means the window never fully appeared on screen.
                if (frame_start) begin
                    state_next      = DONE;
                    incomplete_next = 1'b1;
                end else if (in_win) begin
                    take = 1'b1;
                    if (last_pixel) state_next = DONE;
                end
            end
            DONE: begin
                bus.done_out = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Window origin latch and row/column/address counters (address is a running count).
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            xr       <= '0;
            yr       <= '0;
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
        end else if (latch_req) begin
            xr       <= bus.x_in;
            yr       <= bus.y_in;
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
        end else if (take) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Registered RAM write port; address and data hold between writes.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            bus.we_out   <= 1'b0;
            bus.addr_out <= '0;
            bus.data_out <= '0;
        end else begin
            bus.we_out <= take;
            if (take) begin
                bus.addr_out <= addr_cnt;
                bus.data_out <= to_rgb332(bus.pixel_in);
            end
        end
    end
endmodule

// File: tb/tb_sprite_capture_writer.sv
// Bench for sprite_capture_writer: scenario streams of pixels are built in queues, a
// frame-level reference model derives the expected per-cycle outputs, and each test compares.
module tb_sprite_capture_writer;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int AW   = $clog2(W * H);
    localparam int VW   = AW + 12;
    localparam int NCOL = 22;
    localparam int NROW = 8;
    localparam int B_WE = VW - 1;
    localparam int B_BS = VW - 2;
    localparam int B_DN = VW - 3;
    localparam int B_IC = VW - 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   hold_addr = 0;

    sprite_capture_writer_if #(.ADDR_W(AW)) bus ();

    sprite_capture_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    bit            s_req[$];
    bit            s_val[$];
    bit            s_rst[$];
    int            s_x[$];
    int            s_y[$];
    int            s_h[$];
    int            s_v[$];
    int            s_pix[$];
    logic [VW-1:0] obs[$];
    logic [VW-1:0] expv[$];

    // Reduced frame: columns 0..15 plus the right screen edge 1274..1279.
    function automatic int col_at(int i);
        return (i < 16) ? i : 1258 + i;
    endfunction

    function automatic bit fs_at(int k);
        return s_val[k] && (s_h[k] == 0) && (s_v[k] == 0);
    endfunction

    function automatic int conv(int pix);
        int r = (pix >> 8) & 15;
        int g = (pix >> 4) & 15;
        int b = pix & 15;
        return (r / 2) * 32 + (g / 2) * 4 + (b / 4);
    endfunction

    function automatic int count_bit(int b);
        int c = 0;
        foreach (obs[k]) if (obs[k][b] === 1'b1) c++;
        return c;
    endfunction

    function automatic int find_pix(int h, int v);
        for (int k = 0; k < s_h.size(); k++)
            if (s_val[k] && s_h[k] == h && s_v[k] == v) return k;
        return -1;
    endfunction

    task automatic clear_stream();
        s_req.delete(); s_val.delete(); s_rst.delete(); s_x.delete(); s_y.delete();
        s_h.delete(); s_v.delete(); s_pix.delete(); obs.delete(); expv.delete();
    endtask

    task automatic push(bit req, int x, int y, bit val, int h, int v, int pix);
        s_req.push_back(req); s_x.push_back(x); s_y.push_back(y); s_val.push_back(val);
        s_h.push_back(h); s_v.push_back(v); s_pix.push_back(pix); s_rst.push_back(1'b0);
    endtask

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) push(1'b0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic push_frame(int valid_pct, bit extra_req, int pin_h, int pin_v, int pin_pix);
        for (int v = 0; v < NROW; v++) begin
            for (int i = 0; i < NCOL; i++) begin
                int h   = col_at(i);
                bit val = ($urandom_range(0, 99) < valid_pct);
                int pix = $urandom_range(0, 4095);
                bit req = extra_req && (v == 1 || v == 5) && (i % 5 == 0);
                if (h == 0 && v == 0) val = 1'b1;
                if (h == pin_h && v == pin_v) begin
                    val = 1'b1;
                    pix = pin_pix;
                end
                push(req, $urandom_range(0, 1279), $urandom_range(0, 719), val, h, v, pix);
            end
            push_idle(2);
        end
    endtask

    // Request, one full frame, then the frame start of the following frame.
    task automatic build_capture(int x, int y, int valid_pct, bit extra_req,
                                 int pin_h, int pin_v, int pin_pix);
        clear_stream();
        push_idle(2);
        push(1'b1, x, y, 1'b0, 0, 0, 0);
        push_idle(3);
        push_frame(valid_pct, extra_req, pin_h, pin_v, pin_pix);
        push(1'b0, 0, 0, 1'b1, 0, 0, $urandom_range(0, 4095));
        push_idle(3);
    endtask

    // Reference: the first W*H in-window valid pixels of the first frame after the request
    // are written with addresses 0,1,2,...; running into the next frame start aborts.
    task automatic build_expect();
        int len  = s_req.size();
        int r    = -1;
        int s    = -1;
        int e    = -1;
        int fin  = -1;
        int rstp = -1;
        int n    = 0;
        int stop;
        bit inc  = 1'b0;
        int rank[];
        rank = new[len];
        for (int k = 0; k < len; k++) rank[k] = -1;
        for (int k = 0; k < len; k++) if (s_rst[k] && rstp < 0) rstp = k;
        for (int k = 0; k < len; k++) if (s_req[k] && r < 0) r = k;
        if (r >= 0) for (int k = r + 1; k < len; k++) if (fs_at(k) && s < 0) s = k;
        if (s >= 0) begin
            for (int k = s + 1; k < len; k++) if (fs_at(k) && e < 0) e = k;
            stop = (e < 0) ? len : e;
            for (int k = s; k < stop; k++) begin
                if (n < W * H && s_val[k]
                    && s_h[k] >= s_x[r] && s_h[k] < s_x[r] + W
                    && s_v[k] >= s_y[r] && s_v[k] < s_y[r] + H) begin
                    rank[k] = n;
                    n++;
                    if (n == W * H) fin = k;
                end
            end
            if (fin < 0 && e >= 0) begin
                fin = e;
                inc = 1'b1;
            end
        end
        expv.delete();
        for (int k = 0; k < len; k++) begin
            bit live = (rstp < 0) || (k < rstp);
            bit we   = live && (rank[k] >= 0);
            bit busy = live && (r >= 0) && (k >= r) && (fin < 0 || k < fin);
            bit done = live && (fin >= 0) && (k == fin);
            bit incv = done && inc;
            int data = we ? conv(s_pix[k]) : 0;
            if (!live) hold_addr = 0;
            else if (we) hold_addr = rank[k];
            expv.push_back({we, busy, done, incv, AW'(hold_addr), 8'(data)});
        end
    endtask

    task automatic play();
        obs.delete();
        for (int k = 0; k < s_req.size(); k++) begin
            rst                = s_rst[k];
            bus.capture_req_in = s_req[k];
            bus.x_in           = 11'(s_x[k]);
            bus.y_in           = 10'(s_y[k]);
            bus.pixel_valid_in = s_val[k];
            bus.hcount_in      = 11'(s_h[k]);
            bus.vcount_in      = 10'(s_v[k]);
            bus.pixel_in       = 12'(s_pix[k]);
            @(posedge clk);
            #1;
            obs.push_back({bus.we_out, bus.busy_out, bus.done_out, bus.incomplete_out,
                           bus.addr_out, bus.we_out ? bus.data_out : 8'h00});
        end
        rst                = 1'b0;
        bus.capture_req_in = 1'b0;
        bus.pixel_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.capture_req_in = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.pixel_valid_in = 1'b0;
        bus.hcount_in = '0; bus.vcount_in = '0; bus.pixel_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.we_out !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.we_out); end
        total++; if (bus.addr_out !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.addr_out); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=0", bus.data_out); end
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_out); end
        total++; if (bus.done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_out); end
        total++; if (bus.incomplete_out !== 1'b0) begin bad++; $display("FAIL reset_inc got=%b want=0", bus.incomplete_out); end
        rst = 1'b0;
        hold_addr = 0;
        @(posedge clk);
        #1;
        total++; if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy_out); end
    endtask

    task automatic test_full_capture();
        int p;
        int j = 0;
        build_capture(10, 5, 100, 1'b0, 10, 5, 12'hF84);
        build_expect();
        play();
        for (int k = 0; k < expv.size(); k++) begin
            total++;
            if (obs[k] !== expv[k]) begin bad++; $display("FAIL full_cycle[%0d] got=%h want=%h", k, obs[k], expv[k]); end
        end
        total++; if (count_bit(B_WE) != W * H) begin bad++; $display("FAIL full_writes got=%0d want=%0d", count_bit(B_WE), W * H); end
        foreach (obs[k]) if (obs[k][B_WE] === 1'b1) begin
            total++;
            if (obs[k][AW+7:8] !== AW'(j)) begin bad++; $display("FAIL full_addr_order got=%0d want=%0d", obs[k][AW+7:8], j); end
            j++;
        end
        // r=1111 g=1000 b=0100 -> 111_100_01, written one cycle after pixel (10,5).
        p = find_pix(10, 5);
        total++;
        if (p < 0 || obs[p][B_WE] !== 1'b1 || obs[p][AW+7:8] !== '0 || obs[p][7:0] !== 8'hF1) begin
            bad++; $display("FAIL full_first_word got=%h want we=1 addr=0 data=f1", (p < 0) ? '0 : obs[p]);
        end
        total++; if (count_bit(B_DN) != 1 || count_bit(B_IC) != 0) begin
            bad++; $display("FAIL full_done got=%0d/%0d want=1/0", count_bit(B_DN), count_bit(B_IC));
        end
    endtask

    task automatic test_offscreen();
        int e = s_h.size();
        build_capture(1278, 0, 100, 1'b0, -1, -1, 0);
        build_expect();
        play();
        for (int k = 0; k < expv.size(); k++) begin
            total++;
            if (obs[k] !== expv[k]) begin bad++; $display("FAIL offscreen_cycle[%0d] got=%h want=%h", k, obs[k], expv[k]); end
        end
        total++; if (count_bit(B_WE) != 4) begin bad++; $display("FAIL offscreen_writes got=%0d want=4", count_bit(B_WE)); end
        e = -1;
        for (int k = s_h.size() - 1; k >= 0; k--) if (fs_at(k) && e < 0) e = k;
        total++;
        if (e < 0 || obs[e][B_DN] !== 1'b1 || obs[e][B_IC] !== 1'b1) begin
            bad++; $display("FAIL offscreen_abort got=%b%b want=11", (e < 0) ? 1'b0 : obs[e][B_DN], (e < 0) ? 1'b0 : obs[e][B_IC]);
        end
    endtask

    task automatic test_ignored_req();
        int j = 0;
        build_capture(10, 5, 100, 1'b1, -1, -1, 0);
        build_expect();
        play();
        for (int k = 0; k < expv.size(); k++) begin
            total++;
            if (obs[k] !== expv[k]) begin bad++; $display("FAIL ignreq_cycle[%0d] got=%h want=%h", k, obs[k], expv[k]); end
        end
        foreach (obs[k]) if (obs[k][B_WE] === 1'b1) begin
            total++;
            if (obs[k][AW+7:8] !== AW'(j)) begin bad++; $display("FAIL ignreq_addr got=%0d want=%0d", obs[k][AW+7:8], j); end
            j++;
        end
        total++; if (j != W * H) begin bad++; $display("FAIL ignreq_writes got=%0d want=%0d", j, W * H); end
    endtask

    task automatic test_reset_mid();
        int q;
        build_capture(10, 5, 100, 1'b0, -1, -1, 0);
        q = find_pix(13, 5);
        if (q >= 0) s_rst[q] = 1'b1;
        build_expect();
        play();
        for (int k = 0; k < expv.size(); k++) begin
            total++;
            if (obs[k] !== expv[k]) begin bad++; $display("FAIL rstmid_cycle[%0d] got=%h want=%h", k, obs[k], expv[k]); end
        end
        total++; if (count_bit(B_WE) != 3) begin bad++; $display("FAIL rstmid_writes got=%0d want=3", count_bit(B_WE)); end
        total++; if (count_bit(B_DN) != 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", count_bit(B_DN)); end
        total++;
        if (q < 0 || obs[q][B_WE] !== 1'b0 || obs[q][B_BS] !== 1'b0) begin
            bad++; $display("FAIL rstmid_stop got=%h want we=0 busy=0", (q < 0) ? '0 : obs[q]);
        end
        // Fresh capture at the origin: the frame-start pixel itself is the first write.
        build_capture(0, 0, 100, 1'b0, -1, -1, 0);
        build_expect();
        play();
        for (int k = 0; k < expv.size(); k++) begin
            total++;
            if (obs[k] !== expv[k]) begin bad++; $display("FAIL fresh_cycle[%0d] got=%h want=%h", k, obs[k], expv[k]); end
        end
        q = find_pix(0, 0);
        total++;
        if (q < 0 || obs[q][B_WE] !== 1'b1 || obs[q][AW+7:8] !== '0) begin
            bad++; $display("FAIL fresh_first got=%h want we=1 addr=0", (q < 0) ? '0 : obs[q]);
        end
        total++; if (count_bit(B_WE) != W * H) begin bad++; $display("FAIL fresh_writes got=%0d want=%0d", count_bit(B_WE), W * H); end
    endtask

    task automatic test_valid_toggle();
        int j = 0;
        build_capture(2, 3, 50, 1'b0, -1, -1, 0);
        build_expect();
        play();
        for (int k = 0; k < expv.size(); k++) begin
            total++;
            if (obs[k] !== expv[k]) begin bad++; $display("FAIL toggle_cycle[%0d] got=%h want=%h", k, obs[k], expv[k]); end
        end
        foreach (obs[k]) if (obs[k][B_WE] === 1'b1) begin
            total++;
            if (obs[k][AW+7:8] !== AW'(j)) begin bad++; $display("FAIL toggle_addr got=%0d want=%0d", obs[k][AW+7:8], j); end
            j++;
        end
        total++; if (count_bit(B_DN) != 1) begin bad++; $display("FAIL toggle_done got=%0d want=1", count_bit(B_DN)); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int x = col_at($urandom_range(0, NCOL - 1)) - $urandom_range(0, 3);
            int y = $urandom_range(0, NROW - 1);
            if (x < 0) x = 0;
            build_capture(x, y, (i % 2 == 0) ? 100 : 70, 1'b0, -1, -1, 0);
            build_expect();
            play();
            for (int k = 0; k < expv.size(); k++) begin
                total++;
                if (obs[k] !== expv[k]) begin bad++; $display("FAIL rand%0d_cycle[%0d] x=%0d y=%0d got=%h want=%h", i, k, x, y, obs[k], expv[k]); end
            end
            total++; if (count_bit(B_DN) != 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", i, count_bit(B_DN)); end
        end
    endtask

    initial begin
        test_reset();
        test_full_capture();
        test_offscreen();
        test_ignored_req();
        test_reset_mid();
        test_valid_toggle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
